// File: rtl/bitty_core_p.sv
// Bitty multi-cycle core: fetch/load/execute/write-back over an 8-entry register file.
// Define BITTY_IMM_EN to decode the I-format (ir[1:0]=01); otherwise it is a reserved no-op.
module bitty_core_p #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [15:0]         instruction,
  output logic                done,
  output logic                busy,
  output logic [15:0]         ir,
  output logic [DATA_W-1:0]   reg_s,
  output logic [DATA_W-1:0]   reg_c,
  output logic                flag_c,
  output logic                flag_z,
  output logic [8*DATA_W-1:0] regs
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] s_q, s_d, c_q, c_d;
  logic              fc_q, fc_d, fz_q, fz_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  logic [2:0]        rx;
  logic              fmtOk;
  logic [3:0]        aluSel;
  logic [DATA_W-1:0] aluB, aluRes;
  logic              aluCy;
`ifdef BITTY_IMM_EN
  logic [DATA_W-1:0] immExt;
`endif

  // Operand decode: fmtOk gates every architectural update so reserved formats are no-ops.
  always_comb begin
    rx     = ir_q[15:13];
    fmtOk  = (ir_q[1:0] == 2'b00);
    aluSel = ir_q[5:2];
    aluB   = regs_q[ir_q[12:10]];
`ifdef BITTY_IMM_EN
    immExt      = '0;
    immExt[7:0] = ir_q[12:5];
    if (ir_q[1:0] == 2'b01) begin
      fmtOk  = 1'b1;
      aluSel = {1'b0, ir_q[4:2]};
      aluB   = immExt;
    end
`endif
  end

  always_comb begin
    aluRes = s_q;
    aluCy  = 1'b0;
    case (aluSel)
      4'd0: {aluCy, aluRes} = {1'b0, s_q} + {1'b0, aluB};
      4'd1: begin
        aluRes = s_q - aluB;
        aluCy  = (s_q < aluB);
      end
      4'd2: aluRes = s_q & aluB;
      4'd3: aluRes = s_q | aluB;
      4'd4: aluRes = s_q ^ aluB;
      4'd5: aluRes = ~s_q;
      4'd6: begin
        aluRes = s_q << 1;
        aluCy  = s_q[DATA_W-1];
      end
      4'd7: begin
        aluRes = s_q >> 1;
        aluCy  = s_q[0];
      end
      4'd8: begin
        aluRes = '0;
        if (s_q > aluB)      aluRes[0] = 1'b1;
        else if (s_q < aluB) aluRes[1] = 1'b1;
      end
      default: aluRes = s_q;
    endcase
  end

  // WB can reissue directly, so the register write and the next IR capture share one edge.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    s_d     = s_q;
    c_d     = c_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          ir_d    = instruction;
          state_d = LOAD;
        end
      end
      LOAD: begin
        s_d     = regs_q[rx];
        state_d = EXEC;
      end
      EXEC: begin
        if (fmtOk) begin
          c_d  = aluRes;
          fc_d = aluCy;
          fz_d = (aluRes == '0);
        end
        state_d = WB;
      end
      WB: begin
        if (fmtOk) regs_d[rx] = c_q;
        if (run) begin
          ir_d    = instruction;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      s_q     <= s_d;
      c_q     <= c_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      regs_q  <= regs_d;
    end
  end

  assign done   = (state_q == WB);
  assign busy   = (state_q != IDLE);
  assign ir     = ir_q;
  assign reg_s  = s_q;
  assign reg_c  = c_q;
  assign flag_c = fc_q;
  assign flag_z = fz_q;

  for (genvar g = 0; g < 8; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_bitty_core_p.sv
// Self-checking bench for bitty_core_p: directed vector table, multi-cycle corner sequences,
// and random instructions checked against an arithmetic reference model.
module tb_bitty_core_p;
  localparam int DW  = 16;
  localparam int MOD = 1 << DW;

  logic          clk = 1'b0;
  logic          rst, run;
  logic [15:0]   instruction;
  logic          done, busy, flag_c, flag_z;
  logic [15:0]   ir;
  logic [DW-1:0] reg_s, reg_c;
  logic [8*DW-1:0] regs;

  bitty_core_p #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction),
    .done(done), .busy(busy), .ir(ir), .reg_s(reg_s), .reg_c(reg_c),
    .flag_c(flag_c), .flag_z(flag_z), .regs(regs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          mR [8];
  int          mS, mC, mFc, mFz;
  logic [15:0] mIr;

  typedef struct {
    logic [15:0] ins;
    int          rx;
    int          expR;
    int          expC;
    int          expZ;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [15:0] rf(input int rx, input int ry, input int sel);
    return {rx[2:0], ry[2:0], 4'b0000, sel[3:0], 2'b00};
  endfunction

  function automatic logic [15:0] imf(input int rx, input int imm, input int sel);
    return {rx[2:0], imm[7:0], sel[2:0], 2'b01};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rdReg(input int i);
    return int'(regs[i*DW +: DW]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mR[i] = 0;
    mS = 0; mC = 0; mFc = 0; mFz = 0; mIr = '0;
  endtask

  // Whole-instruction reference: decode the fields and compute the result arithmetically.
  task automatic modelRun(input logic [15:0] ins);
    int rx, sel, a, b, res, cy;
    bit valid;
    rx = int'(ins[15:13]);
    mIr = ins;
    mS = mR[rx];
    valid = 0; sel = 0; b = 0;
    if (ins[1:0] == 2'b00) begin
      valid = 1; sel = int'(ins[5:2]); b = mR[int'(ins[12:10])];
    end
`ifdef BITTY_IMM_EN
    else if (ins[1:0] == 2'b01) begin
      valid = 1; sel = int'(ins[4:2]); b = int'(ins[12:5]);
    end
`endif
    if (valid) begin
      a = mS; cy = 0;
      case (sel)
        0: begin res = (a + b) % MOD; cy = (a + b >= MOD); end
        1: begin res = (a - b + MOD) % MOD; cy = (a < b); end
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: res = MOD - 1 - a;
        6: begin res = (a * 2) % MOD; cy = a / (MOD / 2); end
        7: begin res = a / 2; cy = a % 2; end
        8: res = (a == b) ? 0 : ((a > b) ? 1 : 2);
        default: res = a;
      endcase
      mC = res; mFc = cy; mFz = (res == 0);
      mR[rx] = res;
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", tag, i), rdReg(i), mR[i]);
    chk({tag, "_reg_s"}, reg_s, mS);
    chk({tag, "_reg_c"}, reg_c, mC);
    chk({tag, "_flag_c"}, flag_c, mFc);
    chk({tag, "_flag_z"}, flag_z, mFz);
    chk({tag, "_ir"}, ir, mIr);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Issue one instruction from IDLE and return to IDLE, checking the done/busy timeline.
  task automatic applyStimulus(input logic [15:0] ins);
    int cyc;
    @(negedge clk);
    run = 1'b1; instruction = ins;
    @(negedge clk);
    run = 1'b0; cyc = 1;
    chk("busy_load", busy, 1);
    chk("done_load", done, 0);
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, 3);
    modelRun(ins);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [15:0] b2b [3];
    logic [15:0] insA, insB, rnd;
    int k, doneCnt;

    rst = 1'b1; run = 1'b0; instruction = '0;
    doReset();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    checkOutput("rst");

    tbl[0]  = '{rf(1,0,5),  1, 'hFFFF, 0, 0};
    tbl[1]  = '{rf(2,1,8),  2, 'h0002, 0, 0};
    tbl[2]  = '{rf(1,0,7),  1, 'h7FFF, 1, 0};
    tbl[3]  = '{rf(3,2,1),  3, 'hFFFE, 1, 0};
    tbl[4]  = '{rf(3,1,0),  3, 'h7FFD, 1, 0};
    tbl[5]  = '{rf(3,2,2),  3, 'h0000, 0, 1};
    tbl[6]  = '{rf(3,1,3),  3, 'h7FFF, 0, 0};
    tbl[7]  = '{rf(3,1,4),  3, 'h0000, 0, 1};
    tbl[8]  = '{rf(2,0,6),  2, 'h0004, 0, 0};
    tbl[9]  = '{rf(2,2,8),  2, 'h0000, 0, 1};
    tbl[10] = '{rf(1,0,9),  1, 'h7FFF, 0, 0};
    tbl[11] = '{rf(1,0,6),  1, 'hFFFE, 0, 0};
    tbl[12] = '{rf(1,0,6),  1, 'hFFFC, 1, 0};
    tbl[13] = '{rf(0,0,15), 0, 'h0000, 0, 1};
    tbl[14] = '{16'h2002,   1, 'hFFFC, 0, 1};
    tbl[15] = '{16'h2007,   1, 'hFFFC, 0, 1};
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].ins);
      chk($sformatf("tbl%0d_R", i), rdReg(tbl[i].rx), tbl[i].expR);
      chk($sformatf("tbl%0d_c", i), flag_c, tbl[i].expC);
      chk($sformatf("tbl%0d_z", i), flag_z, tbl[i].expZ);
      checkOutput($sformatf("tbl%0d", i));
    end

    // Wrap-around: R3=FFFF, R4=1, then ADD and SUB.
    applyStimulus(rf(3,0,5));
    applyStimulus(rf(4,0,5));
    applyStimulus(rf(4,0,8));
    chk("wrap_R4", rdReg(4), 1);
    applyStimulus(rf(3,4,0));
    chk("wrap_add_R3", rdReg(3), 0);
    chk("wrap_add_c", flag_c, 1);
    chk("wrap_add_z", flag_z, 1);
    applyStimulus(rf(3,4,1));
    chk("wrap_sub_R3", rdReg(3), 'hFFFF);
    chk("wrap_sub_c", flag_c, 1);
    checkOutput("wrap");

    // Back-to-back: each instruction consumes the register written by its predecessor.
    b2b[0] = rf(4,0,5);
    b2b[1] = rf(4,0,7);
    b2b[2] = rf(5,4,0);
    @(negedge clk);
    run = 1'b1; instruction = b2b[0]; k = 0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_done_cycle", t, 3 * (k + 1));
        if (k < 3) modelRun(b2b[k]);
        k++;
        if (k < 3) instruction = b2b[k];
        else run = 1'b0;
      end
    end
    chk("b2b_done_count", k, 3);
    chk("b2b_busy_end", busy, 0);
    chk("b2b_R5", rdReg(5), 'h7FFF);
    checkOutput("b2b");

    // Run pulsed in LOAD and EXEC must be ignored.
    insA = rf(6,4,3);
    insB = rf(7,0,5);
    @(negedge clk);
    run = 1'b1; instruction = insA;
    @(negedge clk);
    instruction = insB;
    @(negedge clk);
    chk("busy_ir_exec", ir, insA);
    @(negedge clk);
    run = 1'b0;
    doneCnt = 0;
    if (done) doneCnt++;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    chk("busy_done_count", doneCnt, 1);
    modelRun(insA);
    checkOutput("busy");

    // Reset during EXEC aborts the write.
    doReset();
    @(negedge clk);
    run = 1'b1; instruction = rf(5,0,5);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_R5", rdReg(5), 0);
    rst = 1'b0;
    modelReset();
    checkOutput("abort");

    // Immediate format and CMP.
`ifdef BITTY_IMM_EN
    applyStimulus(imf(1,5,0));
    applyStimulus(imf(2,7,0));
    applyStimulus(rf(1,2,0));
    chk("imm_add_R1", rdReg(1), 12);
    chk("imm_add_c", flag_c, 0);
    chk("imm_add_z", flag_z, 0);
    applyStimulus(imf(6,'hAB,0));
    chk("imm_R6", rdReg(6), 'h00AB);
    applyStimulus(rf(6,0,8));
    chk("cmp_R6", rdReg(6), 1);
`else
    applyStimulus(imf(6,'hAB,0));
    chk("imm_R6", rdReg(6), 0);
    applyStimulus(rf(6,0,8));
    chk("cmp_R6", rdReg(6), 0);
    chk("cmp_z", flag_z, 1);
`endif
    checkOutput("imm");

    // Random instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      rnd = 16'($urandom);
      applyStimulus(rnd);
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
